fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: one outstanding program-memory request, flush/redirect with response discard.
// Optional macro FETCH_QUEUE_STATS_EN adds a saturating fetch_count of pushed responses.
module fetch_queue #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int QUEUE_DEPTH           = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             redirect_valid,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] redirect_pc,
  output logic                             program_mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] program_mem_read_address,
  input  logic                             program_mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] program_mem_read_data,
  output logic                             instr_valid,
  input  logic                             instr_ready,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] instr_pc
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [15:0]                      fetch_count
`endif
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t                           state_r, state_s;
  logic                             rd_valid_r, rd_valid_s;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] rd_addr_r, rd_addr_s;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] fetch_pc_r;
  logic [CW-1:0]                    count_r;
  logic [PW-1:0]                    head_r, tail_r;
  logic                             push_s, pop_s;
  logic [PROGRAM_MEM_DATA_BITS-1:0] data_q_r [QUEUE_DEPTH];
  logic [PROGRAM_MEM_ADDR_BITS-1:0] pc_q_r   [QUEUE_DEPTH];

  assign instr_valid              = (count_r != CW'(0));
  assign instruction              = instr_valid ? data_q_r[head_r] : {PROGRAM_MEM_DATA_BITS{1'b0}};
  assign instr_pc                 = instr_valid ? pc_q_r[head_r] : {PROGRAM_MEM_ADDR_BITS{1'b0}};
  assign program_mem_read_valid   = rd_valid_r;
  assign program_mem_read_address = rd_addr_r;
  assign pop_s                    = instr_valid && instr_ready && !redirect_valid;

  // Next-state and next request-port values; redirect outranks issue and push.
  always_comb begin
    state_s    = state_r;
    rd_valid_s = rd_valid_r;
    rd_addr_s  = rd_addr_r;
    push_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable && !redirect_valid && (count_r < CW'(QUEUE_DEPTH))) begin
          state_s    = REQUEST;
          rd_valid_s = 1'b1;
          rd_addr_s  = fetch_pc_r;
        end else begin
          state_s = IDLE;
        end
      end
      REQUEST: begin
        if (redirect_valid) begin
          if (program_mem_read_ready) begin
            state_s    = IDLE;
            rd_valid_s = 1'b0;
          end else begin
            state_s = DISCARD;
          end
        end else if (program_mem_read_ready) begin
          state_s    = IDLE;
          rd_valid_s = 1'b0;
          push_s     = 1'b1;
        end else begin
          state_s = REQUEST;
        end
      end
      DISCARD: begin
        if (program_mem_read_ready) begin
          state_s    = IDLE;
          rd_valid_s = 1'b0;
        end else begin
          state_s = DISCARD;
        end
      end
      default: begin
        state_s    = IDLE;
        rd_valid_s = 1'b0;
      end
    endcase
  end

  // FSM, request port, fetch PC and queue occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      rd_valid_r <= 1'b0;
      rd_addr_r  <= {PROGRAM_MEM_ADDR_BITS{1'b0}};
      fetch_pc_r <= {PROGRAM_MEM_ADDR_BITS{1'b0}};
      count_r    <= CW'(0);
      head_r     <= PW'(0);
      tail_r     <= PW'(0);
    end else begin
      state_r    <= state_s;
      rd_valid_r <= rd_valid_s;
      rd_addr_r  <= rd_addr_s;
      if (redirect_valid) begin
        fetch_pc_r <= redirect_pc;
        count_r    <= CW'(0);
        head_r     <= PW'(0);
        tail_r     <= PW'(0);
      end else begin
        if (push_s) begin
          tail_r     <= tail_r + PW'(1);
          fetch_pc_r <= fetch_pc_r + PROGRAM_MEM_ADDR_BITS'(1);
        end
        if (pop_s) begin
          head_r <= head_r + PW'(1);
        end
        if (push_s && !pop_s) begin
          count_r <= count_r + CW'(1);
        end else if (pop_s && !push_s) begin
          count_r <= count_r - CW'(1);
        end
      end
    end
  end

  // Queue storage; contents are only observable through the count-qualified head.
  always_ff @(posedge clk) begin
    if (push_s) begin
      data_q_r[tail_r] <= program_mem_read_data;
      pc_q_r[tail_r]   <= fetch_pc_r;
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] fetch_count_r;

  // Saturating count of responses that actually entered the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_r <= 16'h0000;
    end else if (push_s && (fetch_count_r != 16'hFFFF)) begin
      fetch_count_r <= fetch_count_r + 16'h0001;
    end
  end

  assign fetch_count = fetch_count_r;
`endif

endmodule
